config_mem_read_arbiter: RTL and testbench

- Shares the single config memory read port (addr / read_valid / read_data / read_ready handshake) among NUM_REQ requesters.
- Requesters include the inter-layer block scheduler, the intra-layer scheduler and the host loader.
- Arbitration is round-robin with one outstanding memory read at a time.
- Has a per-read timeout so a stalled memory cannot hang the schedulers.

---
 rtl/config_mem_read_arbiter.sv | 138 +++++++++++++
 tb/tb_config_mem_read_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/config_mem_read_arbiter.sv
// Round-robin arbiter sharing one config memory read port among NUM_REQ requesters.
// One outstanding read at a time, with an optional per-read timeout that returns an error response.
module config_mem_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]         req_data_o,
  output logic                      req_err_o,
  output logic [ADDR_W-1:0]         mem_addr_o,
  output logic                      mem_read_valid_o,
  input  logic [DATA_W-1:0]         mem_read_data_i,
  input  logic                      mem_read_ready_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                      busy_o
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_grant;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_REQ-1:0]  r_req_ready;
  logic [DATA_W-1:0]   r_req_data;
  logic                r_req_err;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_mem_valid;
  logic                r_busy;

  logic [ADDR_W-1:0]   w_addr [NUM_REQ];
  logic                w_found;
  logic [ID_W-1:0]     w_grant;
  logic [ID_W-1:0]     w_next_ptr;
  logic [NUM_REQ-1:0]  w_onehot;
  logic                w_timeout;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_addr
      assign w_addr[gi] = req_addr_i[gi*ADDR_W +: ADDR_W];
    end
  endgenerate

  // First active requester at or above rr_ptr; the wrap is explicit so non-power-of-two counts work.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      int idx;
      idx = int'(r_rr_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && req_valid_i[ID_W'(idx)]) begin
        w_found = 1'b1;
        w_grant = ID_W'(idx);
      end
    end
  end

  assign w_next_ptr = (r_grant == ID_W'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
  assign w_onehot   = NUM_REQ'(1) << r_grant;
  assign w_timeout  = (TIMEOUT > 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_grant     <= '0;
      r_cnt       <= '0;
      r_req_ready <= '0;
      r_req_data  <= '0;
      r_req_err   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant     <= w_grant;
            r_mem_addr  <= w_addr[w_grant];
            r_mem_valid <= 1'b1;
            r_cnt       <= '0;
            r_busy      <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (mem_read_ready_i) begin
            r_req_data  <= mem_read_data_i;
            r_mem_valid <= 1'b0;
            r_req_ready <= w_onehot;
            r_req_err   <= 1'b0;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_req_data  <= '0;
            r_mem_valid <= 1'b0;
            r_req_ready <= w_onehot;
            r_req_err   <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          r_req_ready <= '0;
          r_req_err   <= 1'b0;
          r_rr_ptr    <= w_next_ptr;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o      = r_req_ready;
  assign req_data_o       = r_req_data;
  assign req_err_o        = r_req_err;
  assign mem_addr_o       = r_mem_addr;
  assign mem_read_valid_o = r_mem_valid;
  assign grant_id_o       = r_grant;
  assign busy_o           = r_busy;

endmodule

// File: tb/tb_config_mem_read_arbiter.sv
// Directed bench for config_mem_read_arbiter: reset, single read, fairness, pointer resume,
// timeout and reset-during-read, all against hand-computed values.
module tb_config_mem_read_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst_ni;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         req_data;
  logic                      req_err;
  logic [ADDR_W-1:0]         mem_addr;
  logic                      mem_valid;
  logic [DATA_W-1:0]         mem_data;
  logic                      mem_ready;
  logic [ID_W-1:0]           grant_id;
  logic                      busy;

  logic                      echo;
  logic [DATA_W-1:0]         man_data;

  int n_total = 0;
  int n_bad   = 0;

  // Memory model: either echoes the address back as data or returns a manually set word.
  assign mem_data = echo ? mem_addr : man_data;

  always #5 clk = ~clk;

  config_mem_read_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_valid_i     (req_valid),
    .req_addr_i      (req_addr),
    .req_ready_o     (req_ready),
    .req_data_o      (req_data),
    .req_err_o       (req_err),
    .mem_addr_o      (mem_addr),
    .mem_read_valid_o(mem_valid),
    .mem_read_data_i (mem_data),
    .mem_read_ready_i(mem_ready),
    .grant_id_o      (grant_id),
    .busy_o          (busy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Waits (bounded) for a response pulse, sampling on falling edges.
  task automatic wait_pulse(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == '0 && n < 40);
    chk("pulse_seen", 64'(|req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int any;
    int vcnt;
    logic [3:0] order [5];
    logic [ADDR_W-1:0] a;

    order[0] = 4'd0; order[1] = 4'd1; order[2] = 4'd2; order[3] = 4'd3; order[4] = 4'd0;

    // Reset held: outputs stay zero while inputs toggle
    rst_ni = 1'b0; req_valid = '0; req_addr = '0; mem_ready = 1'b0; echo = 1'b0; man_data = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      req_valid = NUM_REQ'($urandom);
      req_addr  = {$urandom, $urandom, $urandom, $urandom};
      mem_ready = 1'($urandom);
      man_data  = $urandom;
      @(negedge clk);
      chk("rst_outputs_zero",
          64'(|{req_ready, req_data, req_err, mem_addr, mem_valid, grant_id, busy}), 64'd0);
    end
    req_valid = '0; mem_ready = 1'b0; man_data = '0;
    req_addr[0*32 +: 32] = 32'h40;
    req_addr[1*32 +: 32] = 32'h4;
    req_addr[2*32 +: 32] = 32'h48;
    req_addr[3*32 +: 32] = 32'h4C;
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_no_valid", 64'(mem_valid), 64'd0);
    chk("post_rst_not_busy", 64'(busy), 64'd0);

    // Fairness: all requesting, memory always ready, data echoes address
    echo = 1'b1; mem_ready = 1'b1; req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_pulse(n);
      a = req_addr[order[t]*32 +: 32];
      chk($sformatf("fair%0d_grant", t), 64'(grant_id), 64'(order[t]));
      chk($sformatf("fair%0d_ready", t), 64'(req_ready), 64'(4'b0001 << order[t]));
      chk($sformatf("fair%0d_data", t), 64'(req_data), 64'(a));
      chk($sformatf("fair%0d_err", t), 64'(req_err), 64'd0);
      if (t > 0) chk($sformatf("fair%0d_period", t), 64'(n), 64'd3);
    end
    req_valid = '0; echo = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Single read from requester 1, memory ready on the second ISSUE cycle
    req_valid = 4'b0010;
    @(negedge clk);
    chk("single_mem_valid", 64'(mem_valid), 64'd1);
    chk("single_mem_addr", 64'(mem_addr), 64'h4);
    chk("single_grant", 64'(grant_id), 64'd1);
    chk("single_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("single_no_early_pulse", 64'(req_ready), 64'd0);
    mem_ready = 1'b1; man_data = 32'd222;
    @(negedge clk);
    chk("single_ready", 64'(req_ready), 64'b0010);
    chk("single_data", 64'(req_data), 64'd222);
    chk("single_err", 64'(req_err), 64'd0);
    chk("single_mem_valid_drop", 64'(mem_valid), 64'd0);
    req_valid = '0; mem_ready = 1'b0; man_data = 32'd0;
    @(negedge clk);
    chk("single_pulse_one_cycle", 64'(req_ready), 64'd0);
    chk("single_data_held", 64'(req_data), 64'd222);
    chk("single_idle", 64'(busy), 64'd0);

    // Pointer resume: serve 2, then 0 and 3 together -> 3 first
    mem_ready = 1'b1; man_data = 32'h77; req_valid = 4'b0100;
    wait_pulse(n);
    chk("resume_first_2", 64'(req_ready), 64'b0100);
    req_valid = '0;
    @(negedge clk);
    req_valid = 4'b1001;
    wait_pulse(n);
    chk("resume_3_first", 64'(req_ready), 64'b1000);
    chk("resume_3_grant", 64'(grant_id), 64'd3);
    req_valid = 4'b0001;
    wait_pulse(n);
    chk("resume_0_second", 64'(req_ready), 64'b0001);
    req_valid = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Timeout: memory never ready
    req_valid = 4'b0100;
    vcnt = 0;
    @(negedge clk);
    while (mem_valid && vcnt < 20) begin
      vcnt++;
      @(negedge clk);
    end
    chk("timeout_issue_cycles", 64'(vcnt), 64'd8);
    chk("timeout_ready", 64'(req_ready), 64'b0100);
    chk("timeout_err", 64'(req_err), 64'd1);
    chk("timeout_data_zero", 64'(req_data), 64'd0);
    req_valid = '0; mem_ready = 1'b1; man_data = 32'h55;
    @(negedge clk);
    chk("timeout_pulse_end", 64'(req_ready), 64'd0);
    chk("timeout_err_clear", 64'(req_err), 64'd0);
    repeat (2) @(negedge clk);
    chk("late_ready_ignored_ready", 64'(req_ready), 64'd0);
    chk("late_ready_ignored_data", 64'(req_data), 64'd0);
    chk("late_ready_no_valid", 64'(mem_valid), 64'd0);
    mem_ready = 1'b0;

    // Reset while a read is outstanding
    req_valid = 4'b0010;
    @(negedge clk);
    chk("midrst_valid_before", 64'(mem_valid), 64'd1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_async_valid", 64'(mem_valid), 64'd0);
    chk("midrst_async_busy", 64'(busy), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst_ni = 1'b1;
    any = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (req_ready != '0) any = 1;
    end
    chk("midrst_no_pulse", 64'(any), 64'd0);
    mem_ready = 1'b1; man_data = 32'h99; req_valid = 4'b1010;
    wait_pulse(n);
    chk("midrst_ptr_1_first", 64'(req_ready), 64'b0010);
    chk("midrst_data", 64'(req_data), 64'h99);
    req_valid = 4'b1000;
    wait_pulse(n);
    chk("midrst_3_second", 64'(req_ready), 64'b1000);
    req_valid = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
